// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core-side requesters, the shared memory and mem_port_arbiter.
// slave = arbiter view, master = environment (core requesters plus memory) view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_done, i_rdata, d_done, d_rdata, m_req, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_done, i_rdata, d_done, d_rdata, m_req, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is D priority with an I starvation guard.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t        state;
  logic          grant_i;
  logic          grant_d;
  logic          pick_d;

  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic          i_done_q;
  logic          d_done_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          busy_q;

  // pick_d only matters when both requesters are pending in IDLE.
  always_comb begin
    grant_d = bus.d_req && (!bus.i_req || pick_d);
    grant_i = bus.i_req && !grant_d;
  end

`ifdef MEM_ARB_RR_EN
  logic rr_last_d;

  assign pick_d = !rr_last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_d <= 1'b0;
    end else if (state == IDLE && (grant_i || grant_d)) begin
      rr_last_d <= grant_d;
    end
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign pick_d = (starve_cnt != CW'(STARVE_MAX));

  // Counts D grants that overtook a waiting fetch; saturation forces the next contested grant to I.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && bus.i_req && starve_cnt != CW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  // Memory-side outputs are registered at grant time so they depend only on state, never on live requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_BUSY;
            busy_q    <= 1'b1;
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
          end else if (grant_i) begin
            state    <= I_BUSY;
            busy_q   <= 1'b1;
            m_req_q  <= 1'b1;
            m_addr_q <= bus.i_addr;
          end
        end
        I_BUSY: begin
          if (bus.m_ack) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            i_done_q  <= 1'b1;
            i_rdata_q <= bus.m_rdata;
          end
        end
        D_BUSY: begin
          if (bus.m_ack) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            d_done_q  <= 1'b1;
            d_rdata_q <= bus.m_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_done  = i_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Follows MEM_ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int assert_count = 0;
  int fail_count   = 0;

  // Model: owner 0 = none, 1 = I, 2 = D.
  int            m_owner;
  logic [AW-1:0] m_addr_exp;
  logic          m_we_exp;
  logic [DW-1:0] m_wdata_exp;
  int            exp_done;
  logic [DW-1:0] i_rdata_exp;
  logic [DW-1:0] d_rdata_exp;
  int            d_streak;
  int            last_owner;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_owner     = 0;
    m_addr_exp  = '0;
    m_we_exp    = 1'b0;
    m_wdata_exp = '0;
    exp_done    = 0;
    i_rdata_exp = '0;
    d_rdata_exp = '0;
    d_streak    = 0;
    last_owner  = 1;
  endtask

  task automatic compareAll();
    checkOutput("m_req",   64'(bus.m_req),   64'(m_owner != 0));
    checkOutput("busy",    64'(bus.busy),    64'(m_owner != 0));
    checkOutput("m_addr",  64'(bus.m_addr),  (m_owner != 0) ? 64'(m_addr_exp) : 64'd0);
    checkOutput("m_we",    64'(bus.m_we),    (m_owner != 0) ? 64'(m_we_exp) : 64'd0);
    checkOutput("m_wdata", 64'(bus.m_wdata), (m_owner != 0) ? 64'(m_wdata_exp) : 64'd0);
    checkOutput("i_done",  64'(bus.i_done),  64'(exp_done == 1));
    checkOutput("d_done",  64'(bus.d_done),  64'(exp_done == 2));
    checkOutput("i_rdata", 64'(bus.i_rdata), 64'(i_rdata_exp));
    checkOutput("d_rdata", 64'(bus.d_rdata), 64'(d_rdata_exp));
  endtask

  // Drives one cycle of inputs, advances the model across the coming edge, then checks at the next negedge.
  task automatic applyStimulus(input logic i_req, input logic [AW-1:0] i_addr,
                               input logic d_req, input logic d_we, input logic [AW-1:0] d_addr,
                               input logic [DW-1:0] d_wdata, input logic ack, input logic [DW-1:0] rdata);
    int winner;
    bus.i_req   = i_req;
    bus.i_addr  = i_addr;
    bus.d_req   = d_req;
    bus.d_we    = d_we;
    bus.d_addr  = d_addr;
    bus.d_wdata = d_wdata;
    bus.m_ack   = ack;
    bus.m_rdata = rdata;
    exp_done = 0;
    if (m_owner != 0) begin
      if (ack) begin
        exp_done = m_owner;
        if (m_owner == 1) i_rdata_exp = rdata;
        else              d_rdata_exp = rdata;
        m_owner = 0;
      end
    end else if (i_req || d_req) begin
      if (!i_req)      winner = 2;
      else if (!d_req) winner = 1;
      else begin
`ifdef MEM_ARB_RR_EN
        winner = (last_owner == 1) ? 2 : 1;
`else
        winner = (d_streak == SM) ? 1 : 2;
`endif
      end
`ifdef MEM_ARB_RR_EN
      last_owner = winner;
`else
      if (winner == 1) d_streak = 0;
      else if (i_req && d_streak < SM) d_streak++;
`endif
      m_owner = winner;
      if (winner == 2) begin
        m_addr_exp  = d_addr;
        m_we_exp    = d_we;
        m_wdata_exp = d_wdata;
      end else begin
        m_addr_exp  = i_addr;
        m_we_exp    = 1'b0;
        m_wdata_exp = '0;
      end
    end
    @(negedge clk);
    compareAll();
  endtask

  int exp_order[10];
  int obs_owner;
  logic          ri_req, rd_req, rd_we, r_ack;
  logic [AW-1:0] ri_addr, rd_addr;
  logic [DW-1:0] rd_wdata;

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_order = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
`else
    exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
`endif
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.m_ack = 0; bus.m_rdata = '0;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    reset = 1'b1;

    // Single fetch, ack in the first busy cycle.
    applyStimulus(1, 32'h100, 0, 0, '0, '0, 0, '0);
    checkOutput("fetch_m_addr", 64'(bus.m_addr), 64'h100);
    applyStimulus(1, 32'h100, 0, 0, '0, '0, 1, 32'h00500093);
    checkOutput("fetch_done", 64'(bus.i_done), 64'd1);
    checkOutput("fetch_rdata", 64'(bus.i_rdata), 64'h00500093);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);

    // Sustained contention with stores from D and immediate acks.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, '0);
      obs_owner = (bus.m_addr == 32'h2000) ? 2 : 1;
      checkOutput("grant_order", 64'(obs_owner), 64'(exp_order[k]));
      if (obs_owner == 2) begin
        checkOutput("store_m_we", 64'(bus.m_we), 64'd1);
        checkOutput("store_m_wdata", 64'(bus.m_wdata), 64'hDEADBEEF);
      end
      applyStimulus(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 1, $urandom);
    end
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);

    // Wait states on a fetch while D arrives and must wait its turn.
    applyStimulus(1, 32'h400, 0, 0, '0, '0, 0, '0);
    applyStimulus(1, 32'h400, 0, 0, '0, '0, 0, '0);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1, 32'h400, 1, 0, 32'h500, '0, 0, '0);
      checkOutput("wait_m_addr", 64'(bus.m_addr), 64'h400);
    end
    applyStimulus(1, 32'h400, 1, 0, 32'h500, '0, 1, 32'h11111111);
    checkOutput("wait_i_done", 64'(bus.i_done), 64'd1);
    applyStimulus(0, '0, 1, 0, 32'h500, '0, 0, '0);
    checkOutput("wait_d_granted", 64'(bus.m_addr), 64'h500);
    applyStimulus(0, '0, 1, 0, 32'h500, '0, 1, 32'h22222222);
    checkOutput("wait_d_rdata", 64'(bus.d_rdata), 64'h22222222);
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'h33333333);

    // Random traffic: requests held until done, occasional owner drop, spurious acks while idle.
    ri_req = 0; rd_req = 0; rd_we = 0; ri_addr = '0; rd_addr = '0; rd_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      if (exp_done == 1 || !ri_req) begin
        ri_req  = ($urandom_range(0, 2) != 0);
        ri_addr = $urandom;
      end else if (m_owner == 1 && $urandom_range(0, 15) == 0) begin
        ri_req = 0;
      end
      if (exp_done == 2 || !rd_req) begin
        rd_req   = ($urandom_range(0, 2) != 0);
        rd_we    = $urandom_range(0, 1) == 1;
        rd_addr  = $urandom;
        rd_wdata = $urandom;
      end else if (m_owner == 2 && $urandom_range(0, 15) == 0) begin
        rd_req = 0;
      end
      r_ack = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      applyStimulus(ri_req, ri_addr, rd_req, rd_we, rd_addr, rd_wdata, r_ack, $urandom);
    end
    repeat (3) applyStimulus(0, '0, 0, 0, '0, '0, 1, $urandom);

    // Reset asserted while a load is outstanding.
    applyStimulus(0, '0, 1, 0, 32'h3000, '0, 0, '0);
    checkOutput("rst_pre_busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    checkOutput("rst_m_req", 64'(bus.m_req), 64'd0);
    @(negedge clk);
    compareAll();
    reset = 1'b1;
    applyStimulus(0, '0, 1, 0, 32'h3000, '0, 0, '0);
    checkOutput("rst_rearb_addr", 64'(bus.m_addr), 64'h3000);
    applyStimulus(0, '0, 1, 0, 32'h3000, '0, 1, 32'h5A5A5A5A);
    checkOutput("rst_rearb_done", 64'(bus.d_done), 64'd1);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
